exc_redirect_ctrl: RTL and testbench
====================================

Name: exc_redirect_ctrl

Overview:
- Sequences pipeline recovery once the M-stage exception unit reports a non-NOEXC `excepttype`.
- Captures the exception context and waits out any memory/divider stall.
- Issues a CP0 commit strobe (or ERET strobe), then holds a multi-cycle flush.
- Finally drives the PC redirect to the fetch unit and holds it until fetch accepts it.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_o is held in COMMIT state (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- excepttype_i  in  32  exception code from the exception unit (`EXC_TYPE_*` from defines.vh)
- newpc_i  in  32  redirect target (0xBFC00380 vector, or EPC for ERET)
- pcM_i  in  32  PC of the M-stage instruction
- is_in_delayslot_i  in  1  M-stage instruction is in a branch delay slot
- stall_i  in  1  M/W stage stalled (data memory or mult/div busy)
- fetch_ready_i  in  1  fetch unit accepts a redirect this cycle
- flush_o  out  1  flush the F/D/E/M pipeline registers
- busy_o  out  1  controller not in IDLE; front end must hold
- cp0_we_o  out  1  one-cycle strobe: CP0 latches EPC, Cause.ExcCode and Cause.BD, and sets Status.EXL
- eret_o  out  1  one-cycle strobe: CP0 clears Status.EXL
- cp0_exctype_o  out  32  captured excepttype
- cp0_epc_o  out  32  captured EPC
- cp0_bd_o  out  1  captured branch-delay flag
- pc_redirect_o  out  1  redirect valid
- pc_target_o  out  32  captured redirect target

Behaviour:
- Reset (async): state=IDLE. All outputs 0; capture registers 0; counter 0.
- Pending: excepttype_i != `EXC_TYPE_NOEXC`.
- IDLE, pending, on a clock edge:
  - Capture exctype=excepttype_i and target=newpc_i.
  - bd=is_in_delayslot_i.
  - epc = pcM_i - 4 if bd, else pcM_i (32-bit wraparound: pcM_i=0 with bd gives 0xFFFFFFFC).
  - Next state: HOLD if stall_i=1, else COMMIT.
- HOLD: busy_o=1; all other outputs 0. Exit to COMMIT on the first cycle with stall_i=0.
- COMMIT, entry cycle:
  - cp0_we_o=1 if captured exctype != `EXC_TYPE_ERET`; eret_o=1 if it equals `EXC_TYPE_ERET`.
  - Exactly one of the two strobes fires, for exactly one cycle.
- COMMIT, every cycle: flush_o=1, busy_o=1. The counter starts at 0 and increments each cycle; the state advances to REDIRECT after exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - pc_redirect_o=1, pc_target_o=captured target, flush_o=1, busy_o=1.
  - When fetch_ready_i=1, the handshake completes that cycle and the next state is IDLE.
  - Target is stable while waiting.
- Latency, no stall, fetch_ready_i held 1: detect edge -> COMMIT for FLUSH_CYCLES cycles -> REDIRECT 1 cycle -> IDLE. Total busy = FLUSH_CYCLES+1 cycles.
- In IDLE, cp0_exctype_o, cp0_epc_o, cp0_bd_o and pc_target_o drive 0. In all other states they drive the captured values.
- Ignored inputs:
  - While not IDLE, excepttype_i, newpc_i, pcM_i and is_in_delayslot_i are ignored. Capture happens once per event; the pipeline is being flushed.
  - stall_i is ignored in COMMIT and REDIRECT.
- Back-to-back: a pending exception seen in the same cycle the REDIRECT handshake completes is not captured. It is only captured once the controller is in IDLE on the next edge.
- Reset asserted in any state returns to IDLE immediately: strobes drop, and a redirect is abandoned without a handshake.
- cp0_we_o and eret_o never assert outside the COMMIT entry cycle, and never both at once.

Test Plan:
- Syscall, no stall:
  - Stimulus: excepttype=`EXC_TYPE_SYS`, newpc=0xBFC00380, pcM=0xBFC01004, bd=0, fetch_ready=1, FLUSH_CYCLES=1.
  - Response: next cycle cp0_we_o=1, flush_o=1, cp0_epc_o=0xBFC01004; the following cycle pc_redirect_o=1 with target 0xBFC00380; then IDLE with busy_o=0.
- Delay-slot overflow:
  - Stimulus: `EXC_TYPE_OV` with pcM=0xBFC00020, bd=1.
  - Response: cp0_epc_o=0xBFC0001C, cp0_bd_o=1.
- Stall then commit:
  - Stimulus: exception raised with stall_i=1 for 5 cycles; inputs change to NOEXC during the stall.
  - Response: HOLD for 5 cycles with no strobe; then cp0_we_o pulses once with the originally captured values.
- ERET:
  - Stimulus: `EXC_TYPE_ERET`, newpc=0x80001234.
  - Response: eret_o pulses 1 cycle, cp0_we_o stays 0; redirect target is 0x80001234.
- Redirect backpressure:
  - Stimulus: FLUSH_CYCLES=3, fetch_ready_i=0 for 4 cycles in REDIRECT.
  - Response: flush_o high for 3 cycles in COMMIT; pc_redirect_o and pc_target_o held stable for 4 cycles; exits the cycle after fetch_ready_i rises.
- Async reset mid-REDIRECT:
  - Stimulus: assert rst between clock edges.
  - Response: all outputs 0 immediately. After release, a new exception is captured normally.

Source files
------------

// File: rtl/exc_redirect_ctrl.sv
// Exception recovery sequencer: capture context, wait out stalls, commit to CP0, flush, redirect fetch.
// Latency: FLUSH_CYCLES+1 busy cycles without stall; waits in REDIRECT while fetch_ready_i is low.
module exc_redirect_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] newpc_i,
   input  logic [31:0] pcM_i,
   input  logic        is_in_delayslot_i,
   input  logic        stall_i,
   input  logic        fetch_ready_i,
   output logic        flush_o,
   output logic        busy_o,
   output logic        cp0_we_o,
   output logic        eret_o,
   output logic [31:0] cp0_exctype_o,
   output logic [31:0] cp0_epc_o,
   output logic        cp0_bd_o,
   output logic        pc_redirect_o,
   output logic [31:0] pc_target_o
);

   localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
   localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;
   localparam logic [3:0]  CNT_LAST       = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      COMMIT,
      REDIRECT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [31:0] exctype_q;
   logic [31:0] epc_q;
   logic [31:0] target_q;
   logic        bd_q;
   logic        pending;
   logic        capture;

   assign pending = (excepttype_i != EXC_TYPE_NOEXC);
   assign capture = (state_q == IDLE) && pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         exctype_q <= 32'd0;
         epc_q     <= 32'd0;
         target_q  <= 32'd0;
         bd_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         // Counter runs only in COMMIT so it is always 0 on COMMIT entry.
         cnt_q   <= (state_q == COMMIT) ? cnt_q + 4'd1 : 4'd0;
         if (capture) begin
            exctype_q <= excepttype_i;
            target_q  <= newpc_i;
            bd_q      <= is_in_delayslot_i;
            epc_q     <= is_in_delayslot_i ? pcM_i - 32'd4 : pcM_i;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      flush_o       = 1'b0;
      busy_o        = 1'b0;
      cp0_we_o      = 1'b0;
      eret_o        = 1'b0;
      pc_redirect_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending) state_d = stall_i ? HOLD : COMMIT;
         end
         HOLD: begin
            busy_o = 1'b1;
            if (!stall_i) state_d = COMMIT;
         end
         COMMIT: begin
            flush_o = 1'b1;
            busy_o  = 1'b1;
            if (cnt_q == 4'd0) begin
               cp0_we_o = (exctype_q != EXC_TYPE_ERET);
               eret_o   = (exctype_q == EXC_TYPE_ERET);
            end
            if (cnt_q == CNT_LAST) state_d = REDIRECT;
         end
         REDIRECT: begin
            flush_o       = 1'b1;
            busy_o        = 1'b1;
            pc_redirect_o = 1'b1;
            if (fetch_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cp0_exctype_o = (state_q == IDLE) ? 32'd0 : exctype_q;
   assign cp0_epc_o     = (state_q == IDLE) ? 32'd0 : epc_q;
   assign cp0_bd_o      = (state_q == IDLE) ? 1'b0  : bd_q;
   assign pc_target_o   = (state_q == IDLE) ? 32'd0 : target_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: cycle table on a FLUSH_CYCLES=1 instance plus
// hand sequences for stall, backpressure (FLUSH_CYCLES=3 instance) and async reset.
module tb_exc_redirect_ctrl;

   localparam logic [31:0] NOEXC = 32'h0;
   localparam logic [31:0] SYS   = 32'h8;
   localparam logic [31:0] OV    = 32'hc;
   localparam logic [31:0] ERET  = 32'he;
   localparam logic [31:0] VEC   = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] excepttype = 32'd0;
   logic [31:0] newpc = 32'd0;
   logic [31:0] pcm = 32'd0;
   logic        bd = 1'b0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b1;

   logic        flush1, busy1, we1, eret1, bd1o, redir1;
   logic [31:0] xt1, epc1, tgt1;
   logic        flush3, busy3, we3, eret3, bd3o, redir3;
   logic [31:0] xt3, epc3, tgt3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exc_redirect_ctrl #(.FLUSH_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .excepttype_i(excepttype), .newpc_i(newpc), .pcM_i(pcm),
      .is_in_delayslot_i(bd), .stall_i(stall), .fetch_ready_i(fetch_ready),
      .flush_o(flush1), .busy_o(busy1), .cp0_we_o(we1), .eret_o(eret1),
      .cp0_exctype_o(xt1), .cp0_epc_o(epc1), .cp0_bd_o(bd1o),
      .pc_redirect_o(redir1), .pc_target_o(tgt1)
   );

   exc_redirect_ctrl #(.FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .excepttype_i(excepttype), .newpc_i(newpc), .pcM_i(pcm),
      .is_in_delayslot_i(bd), .stall_i(stall), .fetch_ready_i(fetch_ready),
      .flush_o(flush3), .busy_o(busy3), .cp0_we_o(we3), .eret_o(eret3),
      .cp0_exctype_o(xt3), .cp0_epc_o(epc3), .cp0_bd_o(bd3o),
      .pc_redirect_o(redir3), .pc_target_o(tgt3)
   );

   typedef struct {
      logic [31:0] exc, npc, pc;
      logic        dbd, stl, fr;
      logic        flush, busy, we, eret;
      logic [31:0] xt, epc;
      logic        xbd, redir;
      logic [31:0] tgt;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string tag, input logic fl, input logic bs, input logic w,
                       input logic er, input logic [31:0] xt, input logic [31:0] ep,
                       input logic xb, input logic rd, input logic [31:0] tg);
      chk({tag, ".flush"},   32'(flush1), 32'(fl));
      chk({tag, ".busy"},    32'(busy1),  32'(bs));
      chk({tag, ".cp0_we"},  32'(we1),    32'(w));
      chk({tag, ".eret"},    32'(eret1),  32'(er));
      chk({tag, ".exctype"}, xt1,         xt);
      chk({tag, ".epc"},     epc1,        ep);
      chk({tag, ".bd"},      32'(bd1o),   32'(xb));
      chk({tag, ".redir"},   32'(redir1), 32'(rd));
      chk({tag, ".target"},  tgt1,        tg);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] e, input logic [31:0] n, input logic [31:0] p,
                        input logic b, input logic s, input logic f);
      excepttype = e; newpc = n; pcm = p; bd = b; stall = s; fetch_ready = f;
   endtask

   task automatic do_reset();
      drive(NOEXC, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{NOEXC, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{SYS, VEC, 32'hBFC01004, 0, 0, 1, 1, 1, 1, 0, SYS, 32'hBFC01004, 0, 0, VEC};
      tbl[2]  = '{NOEXC, 0, 0, 0, 0, 1,            1, 1, 0, 0, SYS, 32'hBFC01004, 0, 1, VEC};
      tbl[3]  = '{NOEXC, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{OV, VEC, 32'hBFC00020, 1, 0, 1,  1, 1, 1, 0, OV, 32'hBFC0001C, 1, 0, VEC};
      tbl[5]  = '{NOEXC, 0, 0, 0, 0, 1,            1, 1, 0, 0, OV, 32'hBFC0001C, 1, 1, VEC};
      tbl[6]  = '{NOEXC, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{ERET, 32'h80001234, 32'h80000010, 0, 0, 1,
                  1, 1, 0, 1, ERET, 32'h80000010, 0, 0, 32'h80001234};
      tbl[8]  = '{NOEXC, 0, 0, 0, 0, 1,            1, 1, 0, 0, ERET, 32'h80000010, 0, 1, 32'h80001234};
      tbl[9]  = '{NOEXC, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{SYS, VEC, 32'h0, 1, 0, 1,        1, 1, 1, 0, SYS, 32'hFFFFFFFC, 1, 0, VEC};
      tbl[11] = '{SYS, VEC, 32'h100, 0, 0, 1,      1, 1, 0, 0, SYS, 32'hFFFFFFFC, 1, 1, VEC};
      tbl[12] = '{SYS, VEC, 32'h100, 0, 0, 1,      0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{SYS, VEC, 32'h100, 0, 0, 1,      1, 1, 1, 0, SYS, 32'h100, 0, 0, VEC};
      tbl[14] = '{NOEXC, 0, 0, 0, 1, 1,            1, 1, 0, 0, SYS, 32'h100, 0, 1, VEC};
      tbl[15] = '{NOEXC, 0, 0, 0, 1, 1,            0, 0, 0, 0, 0, 0, 0, 0, 0};

      // Reset state, observed while reset is held.
      rst = 1'b1;
      #2;
      chk1("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.busy3", 32'(busy3), 32'd0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].exc, tbl[i].npc, tbl[i].pc, tbl[i].dbd, tbl[i].stl, tbl[i].fr);
         tick();
         chk1($sformatf("tbl%0d", i), tbl[i].flush, tbl[i].busy, tbl[i].we, tbl[i].eret,
              tbl[i].xt, tbl[i].epc, tbl[i].xbd, tbl[i].redir, tbl[i].tgt);
      end

      // Stall: 5 HOLD cycles, inputs change underneath, then one commit with original context.
      do_reset();
      drive(SYS, VEC, 32'h1000, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold%0d.busy", i),  32'(busy1),  32'd1);
         chk($sformatf("hold%0d.we", i),    32'(we1),    32'd0);
         chk($sformatf("hold%0d.eret", i),  32'(eret1),  32'd0);
         chk($sformatf("hold%0d.flush", i), 32'(flush1), 32'd0);
         chk($sformatf("hold%0d.redir", i), 32'(redir1), 32'd0);
         drive(NOEXC, 32'h12345678, 32'h2000, 1'b1, 1'b1, 1'b1);
      end
      stall = 1'b0;
      tick();
      chk1("stall_commit", 1, 1, 1, 0, SYS, 32'h1000, 0, 0, VEC);
      tick();
      chk1("stall_redir", 1, 1, 0, 0, SYS, 32'h1000, 0, 1, VEC);
      tick();
      chk1("stall_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Backpressure on the FLUSH_CYCLES=3 instance.
      do_reset();
      drive(SYS, VEC, 32'h3000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_commit%0d.flush", i), 32'(flush3), 32'd1);
         chk($sformatf("bp_commit%0d.we", i),    32'(we3),    32'(i == 0));
         chk($sformatf("bp_commit%0d.redir", i), 32'(redir3), 32'd0);
         drive(NOEXC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("bp_wait%0d.redir", i),  32'(redir3), 32'd1);
         chk($sformatf("bp_wait%0d.target", i), tgt3,        VEC);
         chk($sformatf("bp_wait%0d.epc", i),    epc3,        32'h3000);
         chk($sformatf("bp_wait%0d.flush", i),  32'(flush3), 32'd1);
      end
      fetch_ready = 1'b1;
      tick();
      chk("bp_exit.busy",  32'(busy3),  32'd0);
      chk("bp_exit.redir", 32'(redir3), 32'd0);

      // Async reset in the middle of a REDIRECT wait.
      do_reset();
      drive(SYS, VEC, 32'h4000, 1'b0, 1'b0, 1'b0);
      tick();
      drive(NOEXC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ar_pre.redir", 32'(redir1), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk1("ar_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(ERET, 32'h80005678, 32'h80000040, 1'b0, 1'b0, 1'b1);
      tick();
      chk1("ar_new_commit", 1, 1, 0, 1, ERET, 32'h80000040, 0, 0, 32'h80005678);
      drive(NOEXC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk1("ar_new_redir", 1, 1, 0, 0, ERET, 32'h80000040, 0, 1, 32'h80005678);
      tick();
      chk1("ar_new_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
